// File: rtl/div32_iter.sv
// div32_iter: iterative restoring divider, one quotient bit per cycle, signed or unsigned
module div32_iter #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             SIGNED_OP,
  input  logic [WIDTH-1:0] DIVIDEND,
  input  logic [WIDTH-1:0] DIVISOR,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] QUOTIENT,
  output logic [WIDTH-1:0] REMAINDER,
  output logic             DIV_BY_ZERO,
  output logic             OVERFLOW
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, dvd_q, dvd_d;
  logic [WIDTH-1:0] quotient_q, quotient_d, remainder_q, remainder_d;
  logic negq_q, negq_d, negr_q, negr_d, dbz_q, dbz_d, ovf_q, ovf_d;
  logic busy_q, busy_d, done_q, done_d;
  logic div_by_zero_q, div_by_zero_d, overflow_q, overflow_d;
  logic accept, sa, sb;
  logic [WIDTH:0] rem_s, diff;
  always_comb begin
    accept = START && (state_q == S_IDLE || state_q == S_DONE);
    sa = SIGNED_OP && DIVIDEND[WIDTH-1];
    sb = SIGNED_OP && DIVISOR[WIDTH-1];
    rem_s = {rem_q, quo_q[WIDTH-1]};
    diff = rem_s - {1'b0, dvs_q};
    state_d = state_q;
    cnt_d = cnt_q;
    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    dvd_d = dvd_q;
    negq_d = negq_q;
    negr_d = negr_q;
    dbz_d = dbz_q;
    ovf_d = ovf_q;
    quotient_d = quotient_q;
    remainder_d = remainder_q;
    div_by_zero_d = div_by_zero_q;
    overflow_d = overflow_q;
    if (accept) begin
      state_d = (DIVISOR == '0) ? S_FIX : S_CALC;
      cnt_d = CW'(WIDTH);
      rem_d = '0;
      quo_d = sa ? -DIVIDEND : DIVIDEND;
      dvs_d = sb ? -DIVISOR : DIVISOR;
      dvd_d = DIVIDEND;
      negq_d = sa ^ sb;
      negr_d = sa;
      dbz_d = DIVISOR == '0;
      ovf_d = SIGNED_OP && DIVIDEND == {1'b1, {(WIDTH-1){1'b0}}} && &DIVISOR;
    end else if (state_q == S_CALC) begin
      rem_d = diff[WIDTH] ? rem_s[WIDTH-1:0] : diff[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
      cnt_d = cnt_q - CW'(1);
      state_d = (cnt_q == CW'(1)) ? S_FIX : S_CALC;
    end else if (state_q == S_FIX) begin
      state_d = S_DONE;
      quotient_d = dbz_q ? '1 : negq_q ? -quo_q : quo_q;
      remainder_d = dbz_q ? dvd_q : negr_q ? -rem_q : rem_q;
      div_by_zero_d = dbz_q;
      overflow_d = ovf_q;
    end else if (state_q == S_DONE) begin
      state_d = S_IDLE;
    end
    busy_d = state_d == S_CALC || state_d == S_FIX;
    done_d = state_d == S_DONE;
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      dvd_q <= '0;
      negq_q <= 1'b0;
      negr_q <= 1'b0;
      dbz_q <= 1'b0;
      ovf_q <= 1'b0;
      quotient_q <= '0;
      remainder_q <= '0;
      div_by_zero_q <= 1'b0;
      overflow_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      dvd_q <= dvd_d;
      negq_q <= negq_d;
      negr_q <= negr_d;
      dbz_q <= dbz_d;
      ovf_q <= ovf_d;
      quotient_q <= quotient_d;
      remainder_q <= remainder_d;
      div_by_zero_q <= div_by_zero_d;
      overflow_q <= overflow_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign BUSY = busy_q;
  assign DONE = done_q;
  assign QUOTIENT = quotient_q;
  assign REMAINDER = remainder_q;
  assign DIV_BY_ZERO = div_by_zero_q;
  assign OVERFLOW = overflow_q;
endmodule

// File: tb/tb_div32_iter.sv
// tb_div32_iter: directed checks of div32_iter latency, signed/unsigned results, flags and reset
module tb_div32_iter;
  logic CLK = 1'b0, RST = 1'b1, START = 1'b0, SIGNED_OP = 1'b0;
  logic [31:0] DIVIDEND = '0, DIVISOR = '0;
  logic BUSY, DONE, DIV_BY_ZERO, OVERFLOW;
  logic [31:0] QUOTIENT, REMAINDER;
  int checks = 0, failures = 0;
  div32_iter #(.WIDTH(32)) dut (
    .CLK(CLK), .RST(RST), .START(START), .SIGNED_OP(SIGNED_OP),
    .DIVIDEND(DIVIDEND), .DIVISOR(DIVISOR), .BUSY(BUSY), .DONE(DONE),
    .QUOTIENT(QUOTIENT), .REMAINDER(REMAINDER),
    .DIV_BY_ZERO(DIV_BY_ZERO), .OVERFLOW(OVERFLOW)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic launch(input logic sg, input logic [31:0] a, input logic [31:0] b);
    @(negedge CLK);
    START = 1'b1;
    SIGNED_OP = sg;
    DIVIDEND = a;
    DIVISOR = b;
    @(posedge CLK);
    #1 START = 1'b0;
  endtask
  task automatic wait_done(output int c);
    c = 0;
    do begin
      @(negedge CLK);
      c++;
    end while (!DONE && c < 200);
  endtask
  task automatic op(input string tag, input logic sg, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] q, input logic [31:0] r, input logic z, input logic v,
                    input int lat);
    int c;
    launch(sg, a, b);
    wait_done(c);
    chk({tag, ".lat"}, c, lat);
    chk({tag, ".q"}, QUOTIENT, q);
    chk({tag, ".r"}, REMAINDER, r);
    chk({tag, ".flags"}, {DIV_BY_ZERO, OVERFLOW}, {z, v});
    @(negedge CLK);
    chk({tag, ".pulse"}, {DONE, BUSY}, 2'b00);
    chk({tag, ".hold"}, QUOTIENT, q);
  endtask
  initial begin
    int c;
    logic [31:0] a, b, ra, rb, p;
    logic sg;
    repeat (2) @(negedge CLK);
    chk("rst.ctl", {BUSY, DONE, DIV_BY_ZERO, OVERFLOW}, 4'b0);
    chk("rst.qr", {QUOTIENT, REMAINDER}, 64'h0);
    RST = 1'b0;
    op("u100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 34);
    op("s-7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0, 34);
    op("s7_-2", 1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 1'b0, 1'b0, 34);
    op("s-100_-7", 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14, 32'hFFFFFFFE, 1'b0, 1'b0, 34);
    op("u5_0", 1'b0, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b1, 1'b0, 2);
    op("u7_100", 1'b0, 32'd7, 32'd100, 32'd0, 32'd7, 1'b0, 1'b0, 34);
    op("smin_-1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0, 1'b1, 34);
    op("umin_-1", 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0, 1'b0, 34);
    op("umax_1", 1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b0, 34);
    @(negedge CLK);
    START = 1'b1;
    SIGNED_OP = 1'b0;
    DIVIDEND = 32'd100;
    DIVISOR = 32'd7;
    @(posedge CLK);
    #1 DIVIDEND = 32'd50;
    DIVISOR = 32'd3;
    wait_done(c);
    chk("b2b.lat1", c, 34);
    chk("b2b.q1", QUOTIENT, 32'd14);
    chk("b2b.r1", REMAINDER, 32'd2);
    @(posedge CLK);
    #1 START = 1'b0;
    repeat (10) @(negedge CLK);
    chk("b2b.busy", BUSY, 1'b1);
    chk("b2b.stable", {QUOTIENT, REMAINDER}, {32'd14, 32'd2});
    wait_done(c);
    chk("b2b.lat2", 34 + 10 + c, 68);
    chk("b2b.q2", QUOTIENT, 32'd16);
    chk("b2b.r2", REMAINDER, 32'd2);
    launch(1'b0, 32'd1000, 32'd3);
    repeat (9) @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    chk("arst.ctl", {BUSY, DONE, DIV_BY_ZERO, OVERFLOW}, 4'b0);
    chk("arst.qr", {QUOTIENT, REMAINDER}, 64'h0);
    @(negedge CLK);
    RST = 1'b0;
    wait_done(c);
    chk("arst.nodone", c, 200);
    for (int i = 0; i < 64; i++) begin
      a = $urandom;
      b = $urandom;
      b = b >> $urandom_range(31, 0);
      if (b == 0) b = 32'd3;
      sg = 1'($urandom_range(1, 0));
      launch(sg, a, b);
      wait_done(c);
      p = QUOTIENT * b + REMAINDER;
      chk("rnd.inv", p, a);
      ra = (sg && REMAINDER[31]) ? -REMAINDER : REMAINDER;
      rb = (sg && b[31]) ? -b : b;
      chk("rnd.mag", ra < rb, 1'b1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
